vx_local_mem: RTL and testbench



---
 rtl/vx_local_mem.sv | 137 +++++++++++++
 tb/tb_vx_local_mem.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_local_mem.sv
// vx_local_mem: line-addressed external-memory stand-in for the Vortex memory port.
// Accepts one request at a time. Writes commit at their accept edge with per-byte
// enables. Reads answer after RSP_LATENCY cycles and hold until mem_rsp_ready.
// The line array starts all-zero at time zero.
module vx_local_mem #(
  parameter int WORD_W      = 32,
  parameter int DRAM_SIZE   = 64,
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 26,
  parameter int TAG_W       = 8,
  parameter int RSP_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_req_valid,
  input  logic                mem_req_rw,
  input  logic [DATA_W/8-1:0] mem_req_byteen,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W-1:0]   mem_req_data,
  input  logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_req_ready,
  output logic                mem_rsp_valid,
  output logic [DATA_W-1:0]   mem_rsp_data,
  output logic [TAG_W-1:0]    mem_rsp_tag,
  input  logic                mem_rsp_ready,
  output logic                busy,
  output logic                tb_addr_out_of_bounds
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DRAM_SIZE > 1) ? $clog2(DRAM_SIZE) : 1;
  localparam int CNT_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;

  if ((DATA_W % WORD_W) != 0) begin : g_bad_word_w
    $error("vx_local_mem: DATA_W must be a multiple of WORD_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic             req_fire;
  logic             addr_in_bounds;
  logic [IDX_W-1:0] idx;

  logic [DATA_W-1:0] mem [DRAM_SIZE];

  // Time-zero contents of the line array.
  initial begin : init_mem
    for (int i = 0; i < DRAM_SIZE; i++) mem[i] = '0;
  end

  assign mem_req_ready  = (state == S_IDLE);
  assign mem_rsp_valid  = (state == S_RESP);
  assign busy           = (state != S_IDLE);
  assign req_fire       = mem_req_valid && mem_req_ready;
  assign addr_in_bounds = (mem_req_addr < ADDR_W'(DRAM_SIZE));
  assign idx            = mem_req_addr[IDX_W-1:0];

  // Byte-masked line write at the accept edge; out-of-bounds writes are dropped.
  // NOTE: the storage array has no reset branch, so contents survive reset and the
  // array can still map onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && req_fire && mem_req_rw && addr_in_bounds) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_req_byteen[i]) begin
          mem[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
        end
      end
    end
  end

  // Capture read line/tag at the accept edge and track the sticky bounds flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rsp_data          <= '0;
      mem_rsp_tag           <= '0;
      tb_addr_out_of_bounds <= 1'b0;
    end else if (req_fire) begin
      if (!addr_in_bounds) begin
        tb_addr_out_of_bounds <= 1'b1;
      end
      if (!mem_req_rw) begin
        mem_rsp_data <= addr_in_bounds ? mem[idx] : '0;
        mem_rsp_tag  <= mem_req_tag;
      end
    end
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. A read always passes through WAIT, so a latency of 1
  // spends one cycle there with the counter already at zero.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req_fire && !mem_req_rw) begin
          state_next = S_WAIT;
          cnt_next   = CNT_W'(RSP_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (mem_rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vx_local_mem.sv
// Self-checking bench for vx_local_mem: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a behavioural model.
module tb_vx_local_mem;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 26;
  localparam int TAG_W  = 8;
  localparam int BYTES  = DATA_W / 8;
  localparam int DRAM   = 64;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [BYTES-1:0]  mem_req_byteen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [TAG_W-1:0]  mem_req_tag;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [TAG_W-1:0]  mem_rsp_tag;
  logic              mem_rsp_ready;
  logic              busy;
  logic              tb_addr_out_of_bounds;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vx_local_mem #(
    .WORD_W(32), .DRAM_SIZE(DRAM), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .TAG_W(TAG_W), .RSP_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req_valid(mem_req_valid),
    .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .busy(busy),
    .tb_addr_out_of_bounds(tb_addr_out_of_bounds)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding read at most, described by its accept edge number. The
  // response is visible from edge acc+LAT until the edge on which rsp_ready is seen.
  logic [DATA_W-1:0] m_mem [DRAM];
  bit                m_pend = 1'b0;
  bit                m_oob  = 1'b0;
  int                m_acc  = 0;
  logic [DATA_W-1:0] m_data = '0;
  logic [TAG_W-1:0]  m_tag  = '0;
  int                cyc    = 0;

  initial begin
    for (int i = 0; i < DRAM; i++) m_mem[i] = '0;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_pend = 1'b0;
      m_oob  = 1'b0;
    end else if (m_pend) begin
      if ((cyc - 1) >= (m_acc + LAT) && mem_rsp_ready) m_pend = 1'b0;
    end else if (mem_req_valid) begin
      if (mem_req_addr >= ADDR_W'(DRAM)) m_oob = 1'b1;
      if (mem_req_rw) begin
        if (mem_req_addr < ADDR_W'(DRAM)) begin
          for (int b = 0; b < BYTES; b++) begin
            if (mem_req_byteen[b]) m_mem[mem_req_addr][b*8 +: 8] = mem_req_data[b*8 +: 8];
          end
        end
      end else begin
        m_pend = 1'b1;
        m_acc  = cyc;
        m_data = (mem_req_addr < ADDR_W'(DRAM)) ? m_mem[mem_req_addr] : '0;
        m_tag  = mem_req_tag;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    logic exp_valid;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_valid = m_pend && (cyc >= m_acc + LAT);
      check("m_req_ready", DATA_W'(mem_req_ready), DATA_W'(!m_pend));
      check("m_rsp_valid", DATA_W'(mem_rsp_valid), DATA_W'(exp_valid));
      check("m_busy", DATA_W'(busy), DATA_W'(m_pend));
      check("m_oob", DATA_W'(tb_addr_out_of_bounds), DATA_W'(m_oob));
      if (exp_valid) begin
        check("m_rsp_data", mem_rsp_data, m_data);
        check("m_rsp_tag", DATA_W'(mem_rsp_tag), DATA_W'(m_tag));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic put_write(input int a, input logic [DATA_W-1:0] d,
                           input logic [BYTES-1:0] be);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = ADDR_W'(a);
    mem_req_data   = d;
    mem_req_byteen = be;
    @(negedge clk);
    mem_req_valid  = 1'b0;
  endtask

  task automatic put_read(input int a, input logic [TAG_W-1:0] t);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = ADDR_W'(a);
    mem_req_tag   = t;
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] line_a5;
    logic [DATA_W-1:0] line_mix;
    line_a5  = {BYTES{8'hA5}};
    line_mix = {{(BYTES-1){8'hA5}}, 8'hFF};

    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    reset          = 1'b1;

    // Reset held 13 cycles.
    repeat (13) @(negedge clk);
    check("rst_ready", DATA_W'(mem_req_ready), DATA_W'(1));
    check("rst_valid", DATA_W'(mem_rsp_valid), DATA_W'(0));
    check("rst_busy", DATA_W'(busy), DATA_W'(0));
    check("rst_oob", DATA_W'(tb_addr_out_of_bounds), DATA_W'(0));
    check("rst_data", mem_rsp_data, '0);
    check("rst_tag", DATA_W'(mem_rsp_tag), DATA_W'(0));
    reset = 1'b0;
    @(negedge clk);

    // Full-line write then read with latency 2.
    put_write(5, line_a5, '1);
    put_read(5, 8'h3C);
    check("rd1_busy_n", DATA_W'(busy), DATA_W'(1));
    check("rd1_valid_n", DATA_W'(mem_rsp_valid), DATA_W'(0));
    @(negedge clk);
    check("rd1_busy_n1", DATA_W'(busy), DATA_W'(1));
    check("rd1_valid_n1", DATA_W'(mem_rsp_valid), DATA_W'(0));
    @(negedge clk);
    check("rd1_valid_n2", DATA_W'(mem_rsp_valid), DATA_W'(1));
    check("rd1_data", mem_rsp_data, line_a5);
    check("rd1_tag", DATA_W'(mem_rsp_tag), DATA_W'(8'h3C));
    @(negedge clk);
    check("rd1_ready_after", DATA_W'(mem_req_ready), DATA_W'(1));

    // Partial write of byte 0, then a read held off by rsp_ready for 4 cycles.
    put_write(5, {BYTES{8'hFF}}, BYTES'(1));
    mem_rsp_ready = 1'b0;
    put_read(5, 8'h44);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("hold_valid", DATA_W'(mem_rsp_valid), DATA_W'(1));
      check("hold_ready", DATA_W'(mem_req_ready), DATA_W'(0));
      check("hold_data", mem_rsp_data, line_mix);
      check("hold_tag", DATA_W'(mem_rsp_tag), DATA_W'(8'h44));
      if (k < 3) @(negedge clk);
    end
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_ready", DATA_W'(mem_req_ready), DATA_W'(1));
    check("hold_release_valid", DATA_W'(mem_rsp_valid), DATA_W'(0));
    check("hold_release_busy", DATA_W'(busy), DATA_W'(0));

    // Out-of-bounds read at DRAM_SIZE.
    put_read(DRAM, 8'h11);
    check("oob_flag_set", DATA_W'(tb_addr_out_of_bounds), DATA_W'(1));
    repeat (2) @(negedge clk);
    check("oob_valid", DATA_W'(mem_rsp_valid), DATA_W'(1));
    check("oob_data", mem_rsp_data, '0);
    check("oob_tag", DATA_W'(mem_rsp_tag), DATA_W'(8'h11));
    @(negedge clk);
    put_write(3, rand_line(), '1);
    @(negedge clk);
    check("oob_sticky", DATA_W'(tb_addr_out_of_bounds), DATA_W'(1));

    // Reset while in WAIT: no response, memory retained.
    put_read(5, 8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", DATA_W'(busy), DATA_W'(0));
    check("mid_rst_oob", DATA_W'(tb_addr_out_of_bounds), DATA_W'(0));
    for (int k = 0; k < 3; k++) begin
      check("mid_rst_no_rsp", DATA_W'(mem_rsp_valid), DATA_W'(0));
      @(negedge clk);
    end
    put_read(5, 8'h23);
    repeat (2) @(negedge clk);
    check("retained_valid", DATA_W'(mem_rsp_valid), DATA_W'(1));
    check("retained_data", mem_rsp_data, line_mix);
    check("retained_tag", DATA_W'(mem_rsp_tag), DATA_W'(8'h23));
    @(negedge clk);

    // Randomized traffic, including requests while not ready and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      mem_req_valid  = ($urandom_range(0, 2) != 0);
      mem_req_rw     = 1'($urandom_range(0, 1));
      mem_req_addr   = ADDR_W'($urandom_range(0, DRAM + 7));
      mem_req_data   = rand_line();
      mem_req_byteen = {$urandom, $urandom};
      mem_req_tag    = TAG_W'($urandom);
      mem_rsp_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    reset         = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
